key_event_sequencer: RTL



---
 rtl/key_event_pkg.sv | 33 +++
 rtl/key_event_fifo.sv | 62 ++++++
 rtl/key_event_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event sequencer.
package key_event_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_ADDR,
    RD_DATA,
    CLEAR,
    ENCODE
  } state_t;

  // Button PIO register offsets
  localparam logic [2:0] PIO_ADDR_DATA = 3'd0;
  localparam logic [2:0] PIO_ADDR_MASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGE = 3'd3;

  // CPU-facing slave register offsets
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int OVF_BIT = 31;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO with occupancy count and a sticky overflow flag.
// A pop frees the head slot in the same cycle, so push+pop when full succeeds.
module key_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       ovf_clear,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the array has no reset; valid entries are tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push sets the flag even if software clears it in the same cycle.
      if (push && !do_push) overflow <= 1'b1;
      else if (ovf_clear)   overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_sequencer.sv
// Avalon-MM master that services an edge-capture button PIO and queues the
// resulting key codes for the CPU behind a small slave register file.
module key_event_sequencer
  import key_event_pkg::*;
#(
  parameter int          NUM_KEYS   = 6,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MASK_INIT  = 16'h003F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        pio_irq,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_read_n,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              next_state;
  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] pend_rest;
  logic [NUM_KEYS-1:0] rd_pend;
  logic [3:0]          code;

  logic [2:0]          addr_d;
  logic                cs_d;
  logic                wn_d;
  logic [31:0]         wd_d;

  logic                rd_req;
  logic                wr_req;
  logic                fifo_pop;
  logic                ovf_clear;
  logic [3:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                overflow;
  logic                irq_en;
  logic                unused_ok;

  assign rd_pend   = m_readdata[NUM_KEYS-1:0];
  assign pend_rest = pend & (pend - 1'b1);
  assign code      = lowest_set(16'(pend));
  assign unused_ok = ^{m_readdata[31:NUM_KEYS], s_writedata[30:1], fifo_full};

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= next_state;
  end

  // FSM next-state logic.
  // INIT waits until its mask write is actually on the bus, because the bus
  // outputs are registered and still hold their reset values on the first cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      INIT:    if (m_chipselect && !m_write_n) next_state = IDLE;
      IDLE:    if (pio_irq) next_state = RD_ADDR;
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: next_state = (rd_pend == '0) ? IDLE : CLEAR;
      CLEAR:   next_state = ENCODE;
      ENCODE:  if (pend_rest == '0) next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // Bus command for the state being entered; registered below so it lines up with that state.
  always_comb begin
    addr_d = PIO_ADDR_EDGE;
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    wd_d   = '0;
    case (next_state)
      INIT: begin
        addr_d = PIO_ADDR_MASK;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = 32'(MASK_INIT[NUM_KEYS-1:0]);
      end
      RD_ADDR: cs_d = 1'b1;
      CLEAR: begin
        // Write back exactly the bits just read; later edges stay pending in the PIO.
        cs_d = 1'b1;
        wn_d = 1'b0;
        wd_d = 32'(rd_pend);
      end
      default: ;
    endcase
  end

  // Registered master outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
    end else begin
      m_address    <= addr_d;
      m_chipselect <= cs_d;
      m_write_n    <= wn_d;
      m_writedata  <= wd_d;
    end
  end

  // Latched capture bits: loaded in RD_DATA, consumed lowest-first in ENCODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      case (state)
        RD_DATA: pend <= rd_pend;
        ENCODE:  pend <= pend_rest;
        default: pend <= pend;
      endcase
    end
  end

  assign rd_req    = s_chipselect & ~s_read_n;
  assign wr_req    = s_chipselect & ~s_write_n;
  assign fifo_pop  = rd_req && (s_address == REG_DATA);
  assign ovf_clear = wr_req && (s_address == REG_STATUS) && s_writedata[OVF_BIT];

  key_event_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (state == ENCODE),
    .push_data (code),
    .pop       (fifo_pop),
    .ovf_clear (ovf_clear),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  // Slave read data, control register and CPU interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (rd_req) begin
        case (s_address)
          REG_DATA:   s_readdata <= fifo_empty ? 32'h0 : {1'b1, 27'b0, fifo_head};
          REG_STATUS: s_readdata <= {overflow, 15'b0, 16'(fifo_count)};
          REG_CTRL:   s_readdata <= {31'b0, irq_en};
          default:    s_readdata <= '0;
        endcase
      end
      if (wr_req && (s_address == REG_CTRL)) irq_en <= s_writedata[0];
      irq <= irq_en && (fifo_count != '0);
    end
  end

endmodule
